// File: rtl/uart_pkg.sv
// uart_pkg: shared UART link types and constants for the transmit and receive paths
package uart_pkg;
  localparam int UART_DATA_BITS = 8;
  localparam int UART_CLKS_PER_BIT = 868;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous FIFO with combinational head read
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic do_push, do_pop;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign rdata = mem[rp];
  // storage array, written at the tail
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= wdata;
  // pointers and occupancy; a simultaneous push and pop leaves the count unchanged
  always_ff @(posedge clk)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/uart_tx.sv
// uart_tx: FIFO-buffered 8-N-1 UART transmitter; define UART_TX_PARITY_EN for an even parity bit
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int FIFO_DEPTH = 4,
  parameter int STOP_BITS = 1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_data,
  input  logic       i_valid,
  output logic       o_ready,
  output logic       o_tx,
  output logic       o_busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  tx_state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] idx, idx_n;
  logic [UART_DATA_BITS-1:0] shift, shift_n, head;
  logic tx_n, pop, full, empty, bit_done;
`ifdef UART_TX_PARITY_EN
  logic par, par_n;
`endif
  uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(UART_DATA_BITS)) u_fifo (
    .clk(i_clk),
    .rst(i_rst),
    .push(i_valid),
    .pop(pop),
    .wdata(i_data),
    .rdata(head),
    .full(full),
    .empty(empty)
  );
  assign o_ready = !full;
  assign o_busy = state != IDLE || !empty;
  assign bit_done = cnt == CW'(CLKS_PER_BIT - 1);
  // next-state logic; a pop from IDLE or from the last stop bit always launches a new start bit
  always_comb begin
    state_n = state;
    cnt_n = bit_done ? '0 : cnt + 1'b1;
    idx_n = idx;
    shift_n = shift;
    tx_n = o_tx;
    pop = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_n = par;
`endif
    case (state)
      IDLE: begin
        cnt_n = '0;
        tx_n = 1'b1;
        pop = !empty;
      end
      START:
        if (bit_done) begin
          state_n = DATA;
          idx_n = '0;
          tx_n = shift[0];
        end
      DATA:
        if (bit_done) begin
          if (idx == 3'd7) begin
            idx_n = '0;
`ifdef UART_TX_PARITY_EN
            state_n = PARITY;
            tx_n = par;
`else
            state_n = STOP;
            tx_n = 1'b1;
`endif
          end else begin
            idx_n = idx + 1'b1;
            shift_n = shift >> 1;
            tx_n = shift[1];
          end
        end
`ifdef UART_TX_PARITY_EN
      PARITY:
        if (bit_done) begin
          state_n = STOP;
          idx_n = '0;
          tx_n = 1'b1;
        end
`endif
      STOP:
        if (bit_done) begin
          if (idx == 3'(STOP_BITS - 1)) begin
            idx_n = '0;
            pop = !empty;
            state_n = empty ? IDLE : state;
          end else idx_n = idx + 1'b1;
        end
      default: begin
        state_n = IDLE;
        tx_n = 1'b1;
      end
    endcase
    if (pop) begin
      state_n = START;
      cnt_n = '0;
      idx_n = '0;
      shift_n = head;
      tx_n = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_n = ^head;
`endif
    end
  end
  // state, counters, shift register and the registered line
  always_ff @(posedge i_clk)
    if (i_rst) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      shift <= '0;
      o_tx <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par <= 1'b0;
`endif
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      idx <= idx_n;
      shift <= shift_n;
      o_tx <= tx_n;
`ifdef UART_TX_PARITY_EN
      par <= par_n;
`endif
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed tests for uart_tx, one-stop and two-stop instances with CLKS_PER_BIT=4
module tb_uart_tx;
  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int FL1 = (10 + P) * CPB;
  localparam int FL2 = (11 + P) * CPB;
  logic clk = 1'b0;
  logic rst1, v1, rdy1, tx1, busy1;
  logic rst2, v2, rdy2, tx2, busy2;
  logic [7:0] d1, d2;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic tr1 [0:4095];
  logic tr2 [0:4095];
  always #5 clk = ~clk;
  uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4), .STOP_BITS(1)) u1 (
    .i_clk(clk), .i_rst(rst1), .i_data(d1), .i_valid(v1),
    .o_ready(rdy1), .o_tx(tx1), .o_busy(busy1)
  );
  uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4), .STOP_BITS(2)) u2 (
    .i_clk(clk), .i_rst(rst2), .i_data(d2), .i_valid(v2),
    .o_ready(rdy2), .o_tx(tx2), .o_busy(busy2)
  );
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    tr1[cyc % 4096] = tx1;
    tr2[cyc % 4096] = tx2;
  end
  function automatic logic exp_bit(input logic [7:0] b, input int j);
    if (j == 0) return 1'b0;
    if (j <= 8) return b[j-1];
    if (P == 1 && j == 9) return ^b;
    return 1'b1;
  endfunction
  function automatic logic [3:0] obs(input int sel, input int s);
    logic [3:0] r;
    for (int c = 0; c < 4; c++) r[c] = sel == 1 ? tr1[(s + c) % 4096] : tr2[(s + c) % 4096];
    return r;
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    rst1 = 1; rst2 = 1; v1 = 0; v2 = 0; d1 = 0; d2 = 0;
    repeat (3) tick;
    checks += 6;
    if (tx1 !== 1'b1) begin errors++; $display("FAIL reset_tx1 got %b want 1", tx1); end
    if (rdy1 !== 1'b1) begin errors++; $display("FAIL reset_ready1 got %b want 1", rdy1); end
    if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy1 got %b want 0", busy1); end
    if (tx2 !== 1'b1) begin errors++; $display("FAIL reset_tx2 got %b want 1", tx2); end
    if (rdy2 !== 1'b1) begin errors++; $display("FAIL reset_ready2 got %b want 1", rdy2); end
    if (busy2 !== 1'b0) begin errors++; $display("FAIL reset_busy2 got %b want 0", busy2); end
    rst1 = 0; rst2 = 0;
    tick;
  endtask
  task automatic test_single(input logic [7:0] b);
    int t0;
    d1 = b; v1 = 1;
    tick;
    v1 = 0;
    checks++;
    if (tx1 !== 1'b1) begin errors++; $display("FAIL single_latency_early got %b want 1", tx1); end
    tick;
    checks++;
    if (tx1 !== 1'b0) begin errors++; $display("FAIL single_start got %b want 0", tx1); end
    t0 = cyc;
    repeat (FL1 - 1) tick;
    checks++;
    if (busy1 !== 1'b1) begin errors++; $display("FAIL single_busy_last got %b want 1", busy1); end
    tick;
    checks += 2;
    if (busy1 !== 1'b0) begin errors++; $display("FAIL single_busy_end got %b want 0", busy1); end
    if (tx1 !== 1'b1) begin errors++; $display("FAIL single_idle_tx got %b want 1", tx1); end
    for (int j = 0; j < 10 + P; j++) begin
      checks++;
      if (obs(1, t0 + 4 * j) !== {4{exp_bit(b, j)}})
        begin errors++; $display("FAIL single_%h_bit%0d got %b want %b", b, j, obs(1, t0 + 4 * j), {4{exp_bit(b, j)}}); end
    end
  endtask
  task automatic test_back_to_back;
    int t0;
    logic [7:0] bs [2];
    bs[0] = 8'hA3; bs[1] = 8'h0F;
    d1 = 8'hA3; v1 = 1;
    tick;
    d1 = 8'h0F;
    tick;
    v1 = 0;
    t0 = cyc;
    repeat (2 * FL1) tick;
    checks++;
    if (busy1 !== 1'b0) begin errors++; $display("FAIL b2b_busy_end got %b want 0", busy1); end
    for (int k = 0; k < 2; k++)
      for (int j = 0; j < 10 + P; j++) begin
        checks++;
        if (obs(1, t0 + k * FL1 + 4 * j) !== {4{exp_bit(bs[k], j)}})
          begin errors++; $display("FAIL b2b_frame%0d_bit%0d got %b want %b", k, j, obs(1, t0 + k * FL1 + 4 * j), {4{exp_bit(bs[k], j)}}); end
      end
  endtask
  task automatic test_fill;
    int t0;
    logic [7:0] want_rdy;
    want_rdy = 8'b0000_1111;
    t0 = 0;
    for (int k = 1; k <= 8; k++) begin
      d1 = 8'(k); v1 = 1;
      tick;
      if (k == 2) t0 = cyc;
      checks++;
      if (rdy1 !== want_rdy[k-1]) begin errors++; $display("FAIL fill_ready_edge%0d got %b want %b", k, rdy1, want_rdy[k-1]); end
    end
    v1 = 0;
    repeat (FL1 - 7) tick;
    checks++;
    if (rdy1 !== 1'b0) begin errors++; $display("FAIL fill_ready_before_pop2 got %b want 0", rdy1); end
    tick;
    checks++;
    if (rdy1 !== 1'b1) begin errors++; $display("FAIL fill_ready_at_pop2 got %b want 1", rdy1); end
    repeat (4 * FL1) tick;
    checks++;
    if (busy1 !== 1'b0) begin errors++; $display("FAIL fill_busy_end got %b want 0", busy1); end
    for (int k = 0; k < 5; k++)
      for (int j = 0; j < 10 + P; j++) begin
        checks++;
        if (obs(1, t0 + k * FL1 + 4 * j) !== {4{exp_bit(8'(k + 1), j)}})
          begin errors++; $display("FAIL fill_frame%0d_bit%0d got %b want %b", k, j, obs(1, t0 + k * FL1 + 4 * j), {4{exp_bit(8'(k + 1), j)}}); end
      end
  endtask
  task automatic test_reset_mid;
    int bad;
    d1 = 8'hFF; v1 = 1;
    tick;
    d1 = 8'h11;
    tick;
    v1 = 0;
    repeat (15) tick;
    checks++;
    if (busy1 !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before got %b want 1", busy1); end
    rst1 = 1;
    tick;
    checks += 3;
    if (tx1 !== 1'b1) begin errors++; $display("FAIL rstmid_tx got %b want 1", tx1); end
    if (rdy1 !== 1'b1) begin errors++; $display("FAIL rstmid_ready got %b want 1", rdy1); end
    if (busy1 !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", busy1); end
    rst1 = 0;
    bad = 0;
    repeat (60) begin
      tick;
      if (tx1 !== 1'b1 || busy1 !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL rstmid_quiet got %0d active cycles want 0", bad); end
  endtask
  task automatic test_stop2;
    int t0;
    d2 = 8'h00; v2 = 1;
    tick;
    v2 = 0;
    tick;
    checks++;
    if (tx2 !== 1'b0) begin errors++; $display("FAIL stop2_start got %b want 0", tx2); end
    t0 = cyc;
    repeat (FL2 - 1) tick;
    checks++;
    if (busy2 !== 1'b1) begin errors++; $display("FAIL stop2_busy_last got %b want 1", busy2); end
    tick;
    checks++;
    if (busy2 !== 1'b0) begin errors++; $display("FAIL stop2_busy_end got %b want 0", busy2); end
    for (int j = 0; j < 11 + P; j++) begin
      checks++;
      if (obs(2, t0 + 4 * j) !== {4{exp_bit(8'h00, j)}})
        begin errors++; $display("FAIL stop2_bit%0d got %b want %b", j, obs(2, t0 + 4 * j), {4{exp_bit(8'h00, j)}}); end
    end
  endtask
`ifdef UART_TX_PARITY_EN
  task automatic test_parity(input logic [7:0] b, input logic want);
    int t0;
    d1 = b; v1 = 1;
    tick;
    v1 = 0;
    tick;
    t0 = cyc;
    repeat (44) tick;
    checks += 2;
    if (busy1 !== 1'b0) begin errors++; $display("FAIL parity_%h_len got busy %b want 0", b, busy1); end
    if (obs(1, t0 + 36) !== {4{want}})
      begin errors++; $display("FAIL parity_%h_bit got %b want %b", b, obs(1, t0 + 36), {4{want}}); end
  endtask
`endif
  initial begin
    test_reset;
    test_single(8'h55);
    test_back_to_back;
    test_fill;
    test_reset_mid;
    test_stop2;
`ifdef UART_TX_PARITY_EN
    test_parity(8'h07, 1'b1);
    test_parity(8'h55, 1'b0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
